m10_byte_feeder: RTL and testbench
==================================

M10_BYTE_FEEDER -- requirements
Module: m10_byte_feeder

Interface
REQ-001 SHALL have parameters (name, default, meaning): BYTES_PER_ROW, 80, packed bytes per image row (8 pixels per byte; BYTES_PER_ROW*8 <= 2048).
REQ-002 SHALL have parameter ROWS, 480, rows per frame.
REQ-003 SHALL have parameter ADDR_W, 16, RAM address width (BYTES_PER_ROW*ROWS <= 2^ADDR_W).
REQ-004 SHALL have ports (name, direction, width, meaning): clk in 1 clock; rst in 1 reset.
REQ-005 SHALL have ports: start in 1 frame-start pulse; busy out 1 frame in progress.
REQ-006 SHALL have ports: ram_rd out 1 read strobe; ram_addr out ADDR_W byte address; ram_q in 8 read data, valid one cycle after ram_rd.
REQ-007 SHALL have ports: idata out 8 packed pixels, MSB = leftmost; hcount out 11 column of the idata MSB pixel; cnt_en out 1 accumulator clear; rd_done out 1 end-of-frame pulse.
REQ-008 SHALL have ports: m10_done in 1 consumer result strobe; m10_data in 32 consumer result; result out 32 latched moment; result_valid out 1 one-cycle result strobe; err out 1 timeout flag.
REQ-009 One clock; reset is synchronous and active-high.

Function
REQ-010 FSM states: IDLE, CLEAR, READ, DRAIN, DONE, WAIT_RES.
REQ-011 IDLE->CLEAR on start; start in any other state SHALL be ignored.
REQ-012 CLEAR: cnt_en=1 for exactly one cycle; err cleared; ->READ.
REQ-013 READ: ram_rd=1 every cycle, ram_addr from 0 incrementing by 1; after address BYTES_PER_ROW*ROWS-1 ->DRAIN.
REQ-014 Column counter c wraps 0..BYTES_PER_ROW-1; row counter increments on wrap.
REQ-015 Pipeline: address issued cycle t; hcount=c*8 driven at t+1; idata=ram_q registered, driven at t+2 (hcount leads matching idata by exactly one cycle).
REQ-016 idata SHALL be 8'h00 whenever no valid byte is presented; hcount SHALL be 0 outside streaming.
REQ-017 DRAIN: 2 cycles until last idata presented; ->DONE.
REQ-018 DONE: rd_done=1 for exactly one cycle, the cycle after the last idata; ->WAIT_RES.
REQ-019 WAIT_RES: on m10_done, result<=m10_data, result_valid=1 for one cycle, ->IDLE.
REQ-020 busy=1 in all states except IDLE.
REQ-021 m10_done outside WAIT_RES SHALL be ignored.
REQ-022 Counters/address SHALL never exceed limits; no wrap-around past the final address.

Reset
REQ-023 rst SHALL force IDLE, zero all counters, and drive: busy=0, ram_rd=0, ram_addr=0, idata=0, hcount=0, cnt_en=0, rd_done=0, result=0, result_valid=0, err=0.
REQ-024 rst mid-frame SHALL abort immediately; no rd_done issued; next start restarts at address 0.

Configuration
REQ-025 Macro M10_TIMEOUT_EN: when defined, WAIT_RES holds a 6-bit counter; if m10_done not seen within 32 cycles, err<=1 (sticky until next CLEAR/rst), result unchanged, ->IDLE.
REQ-026 Without M10_TIMEOUT_EN: WAIT_RES waits indefinitely; err tied 0.

Structure
REQ-027 Shared package m10_pkg: FSM state enum, HCOUNT_W=11, RESULT_W=32, TIMEOUT_CYC=32.
REQ-028 One sub-module natural: m10_addr_gen (column/row counters, address, hcount generation).

Verification (BYTES_PER_ROW=2, ROWS=2, bench with RAM model and m10 consumer model)
REQ-029 Reset asserted 3 cycles -> all outputs 0, busy=0.
REQ-030 RAM all 8'h80, start -> idata 80,80,80,80 with hcount 0,8,0,8 one cycle earlier; cnt_en 1 cycle; rd_done 1 cycle after last byte; result=16, result_valid 1 cycle.
REQ-031 RAM addr0=8'h01, others 0 -> result=7.
REQ-032 start pulsed during READ -> ignored; exactly 4 reads, single rd_done.
REQ-033 rst asserted at second READ cycle -> ram_rd=0 next cycle, no rd_done; new start reads addresses 0..3.
REQ-034 M10_TIMEOUT_EN defined, consumer never pulses m10_done -> err=1 32 cycles after entering WAIT_RES, busy=0, result=0.

Source files
------------

// File: rtl/m10_pkg.sv
// Shared types and constants for the m10 byte feeder: FSM states, widths, timeout length.
package m10_pkg;
   localparam int HCOUNT_W    = 11;
   localparam int RESULT_W    = 32;
   localparam int TIMEOUT_CYC = 32;
   localparam int TMO_W       = 6;
   localparam int COL_W       = 8;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      READ,
      DRAIN,
      DONE,
      WAIT_RES
   } state_t;

   // Eight pixels per byte, so the leftmost pixel column is the byte column times 8.
   function automatic logic [HCOUNT_W-1:0] col_to_hcount(input logic [COL_W-1:0] col);
      return {col, 3'b000};
   endfunction
endpackage

// File: rtl/m10_addr_gen.sv
// Column/row counters and byte address for frame readout; hcount is registered one stage behind.
module m10_addr_gen
   import m10_pkg::*;
#(
   parameter int BYTES_PER_ROW = 80,
   parameter int ROWS          = 480,
   parameter int ADDR_W        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   output logic [ADDR_W-1:0]   addr,
   output logic                last,
   output logic [HCOUNT_W-1:0] hcount_p1
);
   localparam logic [COL_W-1:0]  COL_LAST = COL_W'(BYTES_PER_ROW - 1);
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

   logic [COL_W-1:0]  col;
   logic [ADDR_W-1:0] row;

   assign last = (col == COL_LAST) && (row == ROW_LAST);

   // Counters only run while reading; they hold on the final address rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
      end else if (!last) begin
         addr <= addr + 1'b1;
         if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // ---- stage p1: column of the byte whose read was issued last cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_p1 <= '0;
      end else begin
         hcount_p1 <= run ? col_to_hcount(col) : '0;
      end
   end
endmodule

// File: rtl/m10_byte_feeder.sv
// Streams a packed 1-bpp frame from RAM to a moment accumulator and latches its result.
// Optional build macro: M10_TIMEOUT_EN adds a result-wait timeout driving err.
module m10_byte_feeder
   import m10_pkg::*;
#(
   parameter int BYTES_PER_ROW = 80,
   parameter int ROWS          = 480,
   parameter int ADDR_W        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                ram_rd,
   output logic [ADDR_W-1:0]   ram_addr,
   input  logic [7:0]          ram_q,
   output logic [7:0]          idata,
   output logic [HCOUNT_W-1:0] hcount,
   output logic                cnt_en,
   output logic                rd_done,
   input  logic                m10_done,
   input  logic [RESULT_W-1:0] m10_data,
   output logic [RESULT_W-1:0] result,
   output logic                result_valid,
   output logic                err
);
   state_t state, state_nxt;
   logic   last;
   logic   drn;
   logic   vld_p1;
   logic [7:0] idata_p2;
   logic [HCOUNT_W-1:0] hcount_p1;

`ifdef M10_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   logic [TMO_W-1:0] tmo;
   logic             tmo_hit;
   assign tmo_hit = (tmo == TMO_LAST);
`endif

   m10_addr_gen #(
      .BYTES_PER_ROW(BYTES_PER_ROW),
      .ROWS         (ROWS),
      .ADDR_W       (ADDR_W)
   ) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .run      (ram_rd),
      .addr     (ram_addr),
      .last     (last),
      .hcount_p1(hcount_p1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         drn   <= 1'b0;
      end else begin
         state <= state_nxt;
         drn   <= (state == DRAIN) && !drn;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      ram_rd    = 1'b0;
      cnt_en    = 1'b0;
      rd_done   = 1'b0;
      case (state)
         IDLE:     if (start) state_nxt = CLEAR;
         CLEAR: begin
            cnt_en    = 1'b1;
            state_nxt = READ;
         end
         READ: begin
            ram_rd = 1'b1;
            if (last) state_nxt = DRAIN;
         end
         DRAIN:    if (drn) state_nxt = DONE;
         DONE: begin
            rd_done   = 1'b1;
            state_nxt = WAIT_RES;
         end
         WAIT_RES: begin
            if (m10_done) state_nxt = IDLE;
`ifdef M10_TIMEOUT_EN
            else if (tmo_hit) state_nxt = IDLE;
`endif
         end
         default:  state_nxt = IDLE;
      endcase
   end

   // ---- stage p1: RAM data arrives, valid follows the read strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= ram_rd;
      end
   end

   // ---- stage p2: registered pixel byte, forced to zero when nothing valid is presented
   always_ff @(posedge clk) begin
      if (rst) begin
         idata_p2 <= '0;
      end else begin
         idata_p2 <= vld_p1 ? ram_q : 8'h00;
      end
   end

   assign idata  = idata_p2;
   assign hcount = hcount_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         result_valid <= (state == WAIT_RES) && m10_done;
         if ((state == WAIT_RES) && m10_done) result <= m10_data;
      end
   end

`ifdef M10_TIMEOUT_EN
   // err is sticky across IDLE so software can read it after the frame is abandoned.
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo <= '0;
         err <= 1'b0;
      end else begin
         tmo <= (state == WAIT_RES) ? tmo + 1'b1 : '0;
         if (state == CLEAR) begin
            err <= 1'b0;
         end else if ((state == WAIT_RES) && !m10_done && tmo_hit) begin
            err <= 1'b1;
         end
      end
   end
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_m10_byte_feeder.sv
// Directed bench for m10_byte_feeder (2x2 bytes) with a RAM model and a moment-summing consumer.
module tb_m10_byte_feeder;
   localparam int BPR = 2;
   localparam int NR  = 2;
   localparam int AW  = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, ram_rd, cnt_en, rd_done, result_valid, err;
   logic [AW-1:0] ram_addr;
   logic [7:0]  ram_q;
   logic [7:0]  idata;
   logic [10:0] hcount;
   logic        m10_done;
   logic [31:0] m10_data, result;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      string       name;
      logic [31:0] bytes;
      logic [31:0] exp_res;
   } vec_t;
   vec_t vecs[7];

   always #5 clk = ~clk;

   m10_byte_feeder #(.BYTES_PER_ROW(BPR), .ROWS(NR), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_q(ram_q),
      .idata(idata), .hcount(hcount), .cnt_en(cnt_en), .rd_done(rd_done),
      .m10_done(m10_done), .m10_data(m10_data),
      .result(result), .result_valid(result_valid), .err(err)
   );

   // RAM model: one-cycle read latency, junk on the bus when not reading
   logic [7:0]    mem [4];
   logic [7:0]    ram_q_r = 8'h00;
   logic [AW-1:0] rd_log [16];
   int            rd_n = 0;
   logic          rd_clr = 1'b0;
   assign ram_q = ram_q_r;

   always @(posedge clk) begin
      if (rd_clr) rd_n <= 0;
      if (ram_rd) begin
         ram_q_r <= mem[ram_addr[1:0]];
         if (rd_n < 16) rd_log[rd_n] <= ram_addr;
         if (!rd_clr) rd_n <= rd_n + 1;
      end else begin
         ram_q_r <= 8'hA5;
      end
   end

   // Consumer model: sums x of every set pixel, x taken from the hcount of the previous cycle
   logic [31:0] acc = 0;
   logic [10:0] hprev = 0;
   logic        done_r = 1'b0;
   logic        cons_en = 1'b1;
   logic        man_done = 1'b0;
   assign m10_done = done_r | man_done;
   assign m10_data = man_done ? 32'hDEAD_BEEF : acc;

   function automatic logic [31:0] contrib(input logic [7:0] d, input logic [10:0] h);
      logic [31:0] s;
      s = '0;
      for (int i = 0; i < 8; i++) if (d[i]) s += 32'(h) + 32'(7 - i);
      return s;
   endfunction

   always @(posedge clk) begin
      hprev  <= hcount;
      acc    <= cnt_en ? 32'd0 : acc + contrib(idata, hprev);
      done_r <= cons_en && rd_done;
   end

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(input logic b, input logic ce, input logic rd,
                                        input logic [AW-1:0] a, input logic [10:0] h,
                                        input logic [7:0] d, input logic dn,
                                        input logic rv, input logic e);
      return 64'({b, ce, rd, a, h, d, dn, rv, e});
   endfunction

   task automatic clear_log();
      rd_clr = 1'b1;
      @(negedge clk);
      rd_clr = 1'b0;
   endtask

   // Full frame from IDLE; cycle k counted in negedges after start is raised.
   task automatic run_frame(input int v);
      logic [31:0]   b;
      logic          e_rd;
      logic [AW-1:0] e_a;
      logic [10:0]   e_h;
      logic [7:0]    e_d;
      b = vecs[v].bytes;
      for (int i = 0; i < 4; i++) mem[i] = b[8*i +: 8];
      start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         e_rd = (k >= 2) && (k <= 5);
         e_a  = e_rd ? AW'(k - 2) : '0;
         e_h  = ((k >= 3) && (k <= 6) && (((k - 3) % 2) == 1)) ? 11'd8 : 11'd0;
         e_d  = ((k >= 4) && (k <= 7)) ? b[8*(k-4) +: 8] : 8'h00;
         check($sformatf("%s k%0d", vecs[v].name, k),
               pack(busy, cnt_en, ram_rd, e_rd ? ram_addr : '0, hcount, idata,
                    rd_done, result_valid, err),
               pack((k >= 1) && (k <= 9), k == 1, e_rd, e_a, e_h, e_d,
                    k == 8, k == 10, 1'b0));
         if (k == 10) check({vecs[v].name, " result"}, 64'(result), 64'(vecs[v].exp_res));
      end
   endtask

   initial begin
      int n_rd, n_dn, n_ce;
      vecs[0] = '{"all80",  32'h8080_8080, 32'd16};
      vecs[1] = '{"a0_01",  32'h0000_0001, 32'd7};
      vecs[2] = '{"zero",   32'h0000_0000, 32'd0};
      vecs[3] = '{"a0_ff",  32'h0000_00FF, 32'd28};
      vecs[4] = '{"a3_01",  32'h0100_0000, 32'd15};
      vecs[5] = '{"mixed",  32'h0010_00C3, 32'd17};
      vecs[6] = '{"all_ff", 32'hFFFF_FFFF, 32'd240};

      // reset held three cycles
      repeat (3) @(negedge clk);
      check("reset outputs", pack(busy, cnt_en, ram_rd, ram_addr, hcount, idata,
                                  rd_done, result_valid, err), 64'd0);
      check("reset result", 64'(result), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         run_frame(v);
         @(negedge clk);
      end

      // m10_done outside WAIT_RES is ignored
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      check("idle m10_done rv", 64'(result_valid), 64'd0);
      check("idle m10_done result", 64'(result), 64'd240);
      @(negedge clk);

      // start pulsed again during READ
      clear_log();
      mem[0] = 8'h80; mem[1] = 8'h80; mem[2] = 8'h80; mem[3] = 8'h80;
      start = 1'b1;
      n_dn = 0; n_ce = 0;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         start = (k == 3);
         if (rd_done) n_dn++;
         if (cnt_en) n_ce++;
      end
      n_rd = rd_n;
      check("restart reads", 64'(n_rd), 64'd4);
      check("restart rd_done", 64'(n_dn), 64'd1);
      check("restart cnt_en", 64'(n_ce), 64'd1);
      check("restart idle", 64'({busy, result}), 64'({1'b0, 32'd16}));

      // reset on the second READ cycle aborts the frame
      clear_log();
      mem[0] = 8'h01; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
      start = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("pre-abort reading", 64'(ram_rd), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort rd/busy", 64'({ram_rd, busy}), 64'd0);
      n_dn = 0; n_rd = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (rd_done) n_dn++;
         if (ram_rd) n_rd++;
      end
      check("abort no rd_done", 64'(n_dn), 64'd0);
      check("abort no reads", 64'(n_rd), 64'd0);
      clear_log();
      run_frame(1);
      for (int i = 0; i < 4; i++) check($sformatf("rerun addr%0d", i), 64'(rd_log[i]), 64'(i));
      check("rerun read count", 64'(rd_n), 64'd4);
      @(negedge clk);

      // reset after a nonzero result
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset2 outputs", pack(busy, cnt_en, ram_rd, ram_addr, hcount, idata,
                                   rd_done, result_valid, err), 64'd0);
      check("reset2 result", 64'(result), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // consumer silent: WAIT_RES behaviour
      cons_en = 1'b0;
      mem[0] = 8'h80; mem[1] = 8'h80; mem[2] = 8'h80; mem[3] = 8'h80;
      start = 1'b1;
`ifdef M10_TIMEOUT_EN
      for (int k = 1; k <= 41; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 40) check("tmo k40 err/busy", 64'({err, busy}), 64'({1'b0, 1'b1}));
         if (k == 41) check("tmo k41 err/busy/result", 64'({err, busy, result}),
                            64'({1'b1, 1'b0, 32'd0}));
      end
      repeat (3) @(negedge clk);
      check("tmo err sticky", 64'({err, busy}), 64'({1'b1, 1'b0}));
`else
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("wait k45 err/busy", 64'({err, busy}), 64'({1'b0, 1'b1}));
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      check("late done", 64'({result_valid, busy, result}),
            64'({1'b1, 1'b0, 32'hDEAD_BEEF}));
`endif
      cons_en = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
